vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_timing_gen_if.sv | 36 +++
 rtl/vga_axis_cnt.sv | 60 ++++++
 rtl/vga_timing_gen.sv | 169 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator.
// Contents: axis phase enum, 640x480@60 and 800x600@60 timing presets,
// and a helper that sums the four phase lengths of one axis.
package vga_pkg;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_e;

  // 640x480@60, 25.175 MHz pixel clock, negative syncs
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;
  localparam logic        VGA640_HS_POL   = 1'b0;
  localparam logic        VGA640_VS_POL   = 1'b0;

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FP     = 40;
  localparam int unsigned SVGA800_H_SYNC   = 128;
  localparam int unsigned SVGA800_H_BP     = 88;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FP     = 1;
  localparam int unsigned SVGA800_V_SYNC   = 4;
  localparam int unsigned SVGA800_V_BP     = 23;
  localparam logic        SVGA800_HS_POL   = 1'b1;
  localparam logic        SVGA800_VS_POL   = 1'b1;

  function automatic int unsigned axis_total(input int unsigned len_active,
                                             input int unsigned len_fp,
                                             input int unsigned len_sync,
                                             input int unsigned len_bp);
    return len_active + len_fp + len_sync + len_bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Scan-side bundle of the VGA timing generator.
// master: generator (drives coordinates, strobes, syncs, colour; reads vga_data)
// slave : buffer/DAC side (drives vga_data; reads everything else)
interface vga_timing_gen_if #(
  parameter int unsigned CW = 12
);
  logic [23:0]   vga_data;
  logic [CW-1:0] h_addr;
  logic [CW-1:0] v_addr;
  logic [7:0]    char_col;
  logic [6:0]    char_row;
  logic [3:0]    cell_x;
  logic [3:0]    cell_y;
  logic          frame_start;
  logic          line_start;
  logic          hsync;
  logic          vsync;
  logic          valid;
  logic [7:0]    vga_r;
  logic [7:0]    vga_g;
  logic [7:0]    vga_b;

  modport master (
    input  vga_data,
    output h_addr, v_addr, char_col, char_row, cell_x, cell_y,
           frame_start, line_start, hsync, vsync, valid,
           vga_r, vga_g, vga_b
  );

  modport slave (
    output vga_data,
    input  h_addr, v_addr, char_col, char_row, cell_x, cell_y,
           frame_start, line_start, hsync, vsync, valid,
           vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_axis_cnt.sv
// One scan axis: wrap counter 0..TOTAL-1 with enable, plus phase decode.
// Ports: clk, reset (sync, active-high), en (advance),
//        count (registered), last_c (count at TOTAL-1), phase, active, sync_raw.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int unsigned CW         = 12,
  parameter int unsigned LEN_ACTIVE = 640,
  parameter int unsigned LEN_FP     = 16,
  parameter int unsigned LEN_SYNC   = 96,
  parameter int unsigned LEN_BP     = 48
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last_c,
  output phase_e        phase,
  output logic          active,
  output logic          sync_raw
);

  localparam int unsigned TOTAL = axis_total(LEN_ACTIVE, LEN_FP, LEN_SYNC, LEN_BP);

  // Boundaries are one bit wider so a total of exactly 2^CW still compares correctly
  localparam logic [CW:0]   END_ACTIVE = (CW+1)'(LEN_ACTIVE);
  localparam logic [CW:0]   END_FP     = (CW+1)'(LEN_ACTIVE + LEN_FP);
  localparam logic [CW:0]   END_SYNC   = (CW+1)'(LEN_ACTIVE + LEN_FP + LEN_SYNC);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);

  logic [CW:0] count_w;

  assign count_w = {1'b0, count};
  assign last_c  = (count == LAST);

  // Wrap counter
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= last_c ? '0 : count + CW'(1);
    end
  end

  // Phase decode: active, front porch, sync, back porch
  always_comb begin
    phase = BP;
    if (count_w < END_ACTIVE) begin
      phase = ACTIVE;
    end else if (count_w < END_FP) begin
      phase = FP;
    end else if (count_w < END_SYNC) begin
      phase = SYNC;
    end
  end

  assign active   = (phase == ACTIVE);
  assign sync_raw = (phase == SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator on the pixel clock.
// Ports: pclk, reset (sync, active-high), bus (vga_timing_gen_if.master):
//   stage-0 h_addr/v_addr, cell coordinates and frame/line strobes for the buffer;
//   hsync/vsync/valid delayed by DATA_LAT; vga_r/g/b = vga_data gated by delayed valid.
// Optional feature macro: VGA_CHAR_CELL_EN (character-cell coordinates; tied to 0 when undefined).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CW       = 12,
  parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
  parameter int unsigned H_FP     = VGA640_H_FP,
  parameter int unsigned H_SYNC   = VGA640_H_SYNC,
  parameter int unsigned H_BP     = VGA640_H_BP,
  parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
  parameter int unsigned V_FP     = VGA640_V_FP,
  parameter int unsigned V_SYNC   = VGA640_V_SYNC,
  parameter int unsigned V_BP     = VGA640_V_BP,
  parameter logic        HS_POL   = VGA640_HS_POL,
  parameter logic        VS_POL   = VGA640_VS_POL,
  parameter int unsigned DATA_LAT = 1,
  parameter int unsigned CELL_W   = 9,
  parameter int unsigned CELL_H   = 16
) (
  input  logic             pclk,
  input  logic             reset,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Elaboration-time parameter checks
  if (64'(H_TOTAL) > (64'(1) << CW)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (64'(V_TOTAL) > (64'(1) << CW)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (CELL_W == 0 || CELL_W > 16 || CELL_H == 0 || CELL_H > 16) begin : g_bad_cell
    $error("vga_timing_gen: CELL_W/CELL_H must be 1..16");
  end
  if (DATA_LAT > 7) begin : g_bad_lat
    $error("vga_timing_gen: DATA_LAT must be 0..7");
  end

  logic [CW-1:0] x, y;
  logic          x_last, y_last;
  logic          h_act, v_act;
  logic          h_sync, v_sync;
  phase_e        h_phase, v_phase;
  logic          valid_raw;

  vga_axis_cnt #(
    .CW(CW), .LEN_ACTIVE(H_ACTIVE), .LEN_FP(H_FP), .LEN_SYNC(H_SYNC), .LEN_BP(H_BP)
  ) u_h_cnt (
    .clk(pclk), .reset(reset), .en(1'b1),
    .count(x), .last_c(x_last), .phase(h_phase), .active(h_act), .sync_raw(h_sync)
  );

  vga_axis_cnt #(
    .CW(CW), .LEN_ACTIVE(V_ACTIVE), .LEN_FP(V_FP), .LEN_SYNC(V_SYNC), .LEN_BP(V_BP)
  ) u_v_cnt (
    .clk(pclk), .reset(reset), .en(x_last),
    .count(y), .last_c(y_last), .phase(v_phase), .active(v_act), .sync_raw(v_sync)
  );

  // Phase and vertical wrap are exported by the counters but not needed here
  logic unused_ok;
  assign unused_ok = ^{h_phase, v_phase, y_last};

  // Stage-0 outputs; strobes suppressed while reset is held
  assign valid_raw       = h_act & v_act;
  assign bus.h_addr      = valid_raw ? x : '0;
  assign bus.v_addr      = valid_raw ? y : '0;
  assign bus.frame_start = !reset && (x == '0) && (y == '0);
  assign bus.line_start  = !reset && (x == '0) && v_act;

  // Delay pipe for {hsync, vsync, valid}, aligning them with the buffer read latency
  localparam logic [2:0] PIPE_RST = {~HS_POL, ~VS_POL, 1'b0};

  logic [2:0] raw, dly;

  assign raw = {h_sync ? HS_POL : ~HS_POL, v_sync ? VS_POL : ~VS_POL, valid_raw};

  if (DATA_LAT == 0) begin : g_no_pipe
    assign dly = raw;
  end else if (DATA_LAT == 1) begin : g_pipe1
    logic [2:0] sr;
    always_ff @(posedge pclk) begin
      if (reset) begin
        sr <= PIPE_RST;
      end else begin
        sr <= raw;
      end
    end
    assign dly = sr;
  end else begin : g_pipe_n
    logic [3*DATA_LAT-1:0] sr;
    always_ff @(posedge pclk) begin
      if (reset) begin
        sr <= {DATA_LAT{PIPE_RST}};
      end else begin
        sr <= {sr[3*DATA_LAT-4:0], raw};
      end
    end
    assign dly = sr[3*DATA_LAT-1 -: 3];
  end

  assign bus.hsync = dly[2];
  assign bus.vsync = dly[1];
  assign bus.valid = dly[0];

  // Colour passes only under delayed valid, so blanking never leaks buffer data
  assign {bus.vga_r, bus.vga_g, bus.vga_b} = (dly[0] && !reset) ? bus.vga_data : 24'h0;

`ifdef VGA_CHAR_CELL_EN
  localparam logic [3:0]    CX_LAST = 4'(CELL_W - 1);
  localparam logic [3:0]    CY_LAST = 4'(CELL_H - 1);
  localparam logic [CW-1:0] X_END   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_END   = CW'(V_ACTIVE - 1);

  logic [3:0] cx, cy;
  logic [7:0] col;
  logic [6:0] row;

  // Column cell tracker: holds the cell position of the current x, cleared
  // for the next line once the last active pixel is reached
  always_ff @(posedge pclk) begin
    if (reset || x >= X_END) begin
      cx  <= '0;
      col <= '0;
    end else if (cx == CX_LAST) begin
      cx  <= '0;
      col <= col + 8'(1);
    end else begin
      cx <= cx + 4'(1);
    end
  end

  // Row cell tracker: same rule, advanced once per line
  always_ff @(posedge pclk) begin
    if (reset) begin
      cy  <= '0;
      row <= '0;
    end else if (x_last) begin
      if (y >= Y_END) begin
        cy  <= '0;
        row <= '0;
      end else if (cy == CY_LAST) begin
        cy  <= '0;
        row <= row + 7'(1);
      end else begin
        cy <= cy + 4'(1);
      end
    end
  end

  assign bus.cell_x   = valid_raw ? cx  : '0;
  assign bus.cell_y   = valid_raw ? cy  : '0;
  assign bus.char_col = valid_raw ? col : '0;
  assign bus.char_row = valid_raw ? row : '0;
`else
  assign bus.cell_x   = '0;
  assign bus.cell_y   = '0;
  assign bus.char_col = '0;
  assign bus.char_row = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance (DATA_LAT=1) and a small
// fast-frame instance (DATA_LAT=3, positive hsync), both compared every cycle
// against an arithmetic model of scan position derived from cycles since reset.
// Honours VGA_CHAR_CELL_EN the same way as the design.
module tb_vga_timing_gen;

  typedef struct packed {
    int   ha, hfp, hs, hb, va, vfp, vs, vb, lat, cw, ch;
    logic hpol, vpol;
  } timing_t;

  localparam timing_t P_DEF = '{ha: 640, hfp: 16, hs: 96, hb: 48, va: 480, vfp: 10, vs: 2, vb: 33,
                                 lat: 1, cw: 9, ch: 16, hpol: 1'b0, vpol: 1'b0};
  localparam timing_t P_SM  = '{ha: 40, hfp: 4, hs: 6, hb: 5, va: 20, vfp: 2, vs: 2, vb: 3,
                                 lat: 3, cw: 7, ch: 6, hpol: 1'b1, vpol: 1'b0};

  localparam int DEF_LINE = P_DEF.ha + P_DEF.hfp + P_DEF.hs + P_DEF.hb;
  localparam int SM_FRAME = (P_SM.ha + P_SM.hfp + P_SM.hs + P_SM.hb) *
                            (P_SM.va + P_SM.vfp + P_SM.vs + P_SM.vb);

  logic pclk  = 1'b0;
  logic reset = 1'b1;

  int t = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_fs = -1;
  int last_ls = -1;

  logic [7:0]  b_def = '0;
  logic [7:0]  b_sm  = '0;
  logic [15:0] hq_def[$];
  logic [15:0] hq_sm[$];

  always #5 pclk = ~pclk;

  vga_timing_gen_if #(.CW(12)) bus_def ();
  vga_timing_gen_if #(.CW(8))  bus_sm ();

  vga_timing_gen dut_def (
    .pclk(pclk),
    .reset(reset),
    .bus(bus_def)
  );

  vga_timing_gen #(
    .CW(8),
    .H_ACTIVE(P_SM.ha), .H_FP(P_SM.hfp), .H_SYNC(P_SM.hs), .H_BP(P_SM.hb),
    .V_ACTIVE(P_SM.va), .V_FP(P_SM.vfp), .V_SYNC(P_SM.vs), .V_BP(P_SM.vb),
    .HS_POL(P_SM.hpol), .VS_POL(P_SM.vpol),
    .DATA_LAT(P_SM.lat), .CELL_W(P_SM.cw), .CELL_H(P_SM.ch)
  ) dut_sm (
    .pclk(pclk),
    .reset(reset),
    .bus(bus_sm)
  );

  // Cycles since reset was last released (0 on the first free-running cycle)
  always @(posedge pclk) t <= reset ? 0 : t + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: position from t by division; delayed signals from position at t-lat
  task automatic check_dut(input string n, input timing_t p, input int tt,
                           input logic [31:0] h_addr, input logic [31:0] v_addr,
                           input logic [7:0] col, input logic [6:0] row,
                           input logic [3:0] cx, input logic [3:0] cy,
                           input logic fs, input logic ls,
                           input logic hs, input logic vs, input logic vld,
                           input logic [23:0] rgb, input logic [7:0] bd);
    int   ht, vt, x, y, xd, yd;
    bit   act, actd;
    logic ehs, evs;
    logic [23:0] ergb;
    ht  = p.ha + p.hfp + p.hs + p.hb;
    vt  = p.va + p.vfp + p.vs + p.vb;
    x   = tt % ht;
    y   = (tt / ht) % vt;
    act = (x < p.ha) && (y < p.va);
    check({n, ".h_addr"}, 64'(h_addr), act ? 64'(x) : 64'(0));
    check({n, ".v_addr"}, 64'(v_addr), act ? 64'(y) : 64'(0));
    check({n, ".frame_start"}, 64'(fs), 64'(x == 0 && y == 0));
    check({n, ".line_start"}, 64'(ls), 64'(x == 0 && y < p.va));
`ifdef VGA_CHAR_CELL_EN
    check({n, ".char_col"}, 64'(col), act ? 64'(x / p.cw) : 64'(0));
    check({n, ".char_row"}, 64'(row), act ? 64'(y / p.ch) : 64'(0));
    check({n, ".cell_x"}, 64'(cx), act ? 64'(x % p.cw) : 64'(0));
    check({n, ".cell_y"}, 64'(cy), act ? 64'(y % p.ch) : 64'(0));
`else
    check({n, ".char_col"}, 64'(col), 64'(0));
    check({n, ".char_row"}, 64'(row), 64'(0));
    check({n, ".cell_x"}, 64'(cx), 64'(0));
    check({n, ".cell_y"}, 64'(cy), 64'(0));
`endif
    xd = 0;
    yd = 0;
    if (tt >= p.lat) begin
      xd   = (tt - p.lat) % ht;
      yd   = ((tt - p.lat) / ht) % vt;
      actd = (xd < p.ha) && (yd < p.va);
      ehs  = (xd >= p.ha + p.hfp && xd < p.ha + p.hfp + p.hs) ? p.hpol : !p.hpol;
      evs  = (yd >= p.va + p.vfp && yd < p.va + p.vfp + p.vs) ? p.vpol : !p.vpol;
    end else begin
      actd = 1'b0;
      ehs  = !p.hpol;
      evs  = !p.vpol;
    end
    ergb = actd ? {8'(xd), 8'(yd), bd} : 24'h0;
    check({n, ".hsync"}, 64'(hs), 64'(ehs));
    check({n, ".vsync"}, 64'(vs), 64'(evs));
    check({n, ".valid"}, 64'(vld), 64'(actd));
    check({n, ".rgb"}, 64'(rgb), 64'(ergb));
  endtask

  // Upstream buffer stand-in: returns {h_addr, v_addr} of lat cycles ago plus a random blue
  task automatic step();
    @(posedge pclk);
    #1;
    hq_def.push_back({bus_def.h_addr[7:0], bus_def.v_addr[7:0]});
    while (hq_def.size() > P_DEF.lat + 1) void'(hq_def.pop_front());
    hq_sm.push_back({bus_sm.h_addr[7:0], bus_sm.v_addr[7:0]});
    while (hq_sm.size() > P_SM.lat + 1) void'(hq_sm.pop_front());
    b_def = 8'($urandom);
    b_sm  = 8'($urandom);
    bus_def.vga_data = {hq_def[0], b_def};
    bus_sm.vga_data  = {hq_sm[0], b_sm};
  endtask

  always @(negedge pclk) begin
    if (reset) begin
      check("def.rst.frame_start", 64'(bus_def.frame_start), 64'(0));
      check("def.rst.line_start", 64'(bus_def.line_start), 64'(0));
      check("def.rst.rgb", 64'({bus_def.vga_r, bus_def.vga_g, bus_def.vga_b}), 64'(0));
      check("sm.rst.frame_start", 64'(bus_sm.frame_start), 64'(0));
      check("sm.rst.rgb", 64'({bus_sm.vga_r, bus_sm.vga_g, bus_sm.vga_b}), 64'(0));
      last_fs = -1;
      last_ls = -1;
    end else begin
      check_dut("def", P_DEF, t, 32'(bus_def.h_addr), 32'(bus_def.v_addr),
                bus_def.char_col, bus_def.char_row, bus_def.cell_x, bus_def.cell_y,
                bus_def.frame_start, bus_def.line_start,
                bus_def.hsync, bus_def.vsync, bus_def.valid,
                {bus_def.vga_r, bus_def.vga_g, bus_def.vga_b}, b_def);
      check_dut("sm", P_SM, t, 32'(bus_sm.h_addr), 32'(bus_sm.v_addr),
                bus_sm.char_col, bus_sm.char_row, bus_sm.cell_x, bus_sm.cell_y,
                bus_sm.frame_start, bus_sm.line_start,
                bus_sm.hsync, bus_sm.vsync, bus_sm.valid,
                {bus_sm.vga_r, bus_sm.vga_g, bus_sm.vga_b}, b_sm);
      if (bus_sm.frame_start) begin
        if (last_fs >= 0) check("sm.frame_period", 64'(cyc - last_fs), 64'(SM_FRAME));
        last_fs = cyc;
      end
      if (bus_def.line_start) begin
        if (last_ls >= 0 && bus_def.v_addr != '0)
          check("def.line_period", 64'(cyc - last_ls), 64'(DEF_LINE));
        last_ls = cyc;
      end
    end
    cyc++;
  end

  initial begin
    bus_def.vga_data = '0;
    bus_sm.vga_data  = '0;
    reset = 1'b1;
    repeat (5) step();
    reset = 1'b0;

    // Abort a frame mid-line at x=300, y=5 of the default timing
    repeat (4300) step();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Long run: default cell rows past y=16, several small frames
    repeat (17 * DEF_LINE) step();

    // Randomly placed reset pulses of random length
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(60, 2500)) step();
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      reset = 1'b0;
    end
    repeat (1600) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
